issue_queue_sched: RTL and testbench
====================================

Name: issue_queue_sched

Overview:
- Parametrised, collapsing out-of-order issue queue with an integrated register scoreboard.
- Accepts up to DISP_W decoded instructions per cycle from the decoder.
- Tracks operand readiness against writeback ports and issues up to ISSUE_W ready entries per cycle, oldest-first.
- Supports selective branch-tag flush. Replaces the fixed 2-in/4-out issue stage; sits between decode and the execution units.

Parameters:
- DEPTH, 16, queue entries (>= ISSUE_W).
- DISP_W, 2, dispatch lanes per cycle.
- ISSUE_W, 4, issue lanes per cycle.
- WB_W, 4, writeback ports.
- REG_NUM, 16, architectural registers.
- REG_W, 4, register index width = clog2(REG_NUM).
- OP_W, 4, opcode width.
- IMM_W, 5, immediate width.
- BID_W, 3, branch tag width; 2**BID_W tags.

Ports:
- clk, in, 1: clock.
- rst, in, 1: reset, asynchronous, active-low.
- disp_vld, in, DISP_W: per-lane dispatch valid.
- disp_rdy, out, DISP_W: per-lane accept.
- disp_des, in, DISP_W*REG_W: destination registers.
- disp_s1, in, DISP_W*REG_W: source 1.
- disp_s2, in, DISP_W*REG_W: source 2.
- disp_s1_use, in, DISP_W: source 1 used.
- disp_s2_use, in, DISP_W: source 2 used.
- disp_des_use, in, DISP_W: writes a destination.
- disp_op, in, DISP_W*OP_W: opcode.
- disp_imm, in, DISP_W*IMM_W: immediate.
- disp_bid, in, DISP_W*BID_W: branch tag.
- wb_vld, in, WB_W: writeback valid.
- wb_des, in, WB_W*REG_W: writeback register.
- flush_en, in, 1: flush request.
- flush_bid_mask, in, 2**BID_W: tags to kill.
- flush_reg, in, REG_NUM: scoreboard bits to clear.
- iss_vld, out, ISSUE_W: issue lane valid.
- iss_des, iss_s1, iss_s2, out, ISSUE_W*REG_W: issued fields.
- iss_op, out, ISSUE_W*OP_W: opcode.
- iss_imm, out, ISSUE_W*IMM_W: immediate.
- iss_bid, out, ISSUE_W*BID_W: tag.
- iq_count, out, clog2(DEPTH+1): occupied entries.
- iq_full, out, 1: iq_count == DEPTH.
- iq_empty, out, 1: iq_count == 0.

Behaviour:
- Reset (rst low, async):
  - All entry valid bits = 0 and scoreboard busy bits = 0.
  - iss_* = 0; iq_count = 0, iq_empty = 1, iq_full = 0.
  - disp_rdy is combinational; it is 0 while rst is low.
- Storage: entry 0 is the oldest. Each cycle survivors (not issued, not flushed) collapse toward index 0 preserving order, then accepted dispatches append in lane order.
- Ready: entry is ready when each used source is either not busy or matches any wb_des with wb_vld this cycle (same-cycle wakeup bypass).
- Select: the first ISSUE_W ready entries by index. Lane k receives the k-th selected entry. Lanes are packed: lanes 0..n-1 valid, remainder vld = 0.
- Issue timing:
  - iss_* are registered, 1-cycle latency: selected in cycle t, driven in t+1, removed from the queue at the same edge.
  - Lanes not driven with a valid entry hold all-zero fields.
- Dispatch acceptance (combinational) for lane i requires all of:
  - disp_vld[i];
  - all lanes < i accepted (in-order);
  - free = DEPTH - iq_count + (entries issued this cycle) > i;
  - no WAW hazard: des not busy, and not equal to des of an accepted lane < i (when both use des);
  - flush_en = 0.
- Scoreboard update at the edge:
  - Clear for each wb_vld port.
  - Clear flush_reg bits when flush_en.
  - Set the des of each accepted lane with des_use. Set wins over clear on the same register.
- Flush (flush_en = 1):
  - Entries whose bid bit is set in flush_bid_mask are invalidated and excluded from select that cycle.
  - No dispatch is accepted in the flush cycle.
  - Entries already on iss_* this cycle are not recalled.
- Count: iq_count_next = iq_count - issued - flushed + accepted; it never exceeds DEPTH or underflows.
- Full queue: disp_rdy = 0 unless issues free slots this cycle. Empty queue: iss_vld = 0 next cycle.
- Writeback to a non-busy register: no effect.

Decomposition:
- iq_pkg holds the iq_entry_t struct (vld, des, s1, s2, use bits, op, imm, bid), width localparams, and a clog2 helper.
- One sub-module, iq_oldest_select: DEPTH-bit ready vector in, ISSUE_W one-hot grant vectors out (priority by index).
- Scoreboard and collapse logic stay in the top module.

Test Plan:
- Reset, then dispatch add r1 <- r2,r3 (lanes 0 only), registers idle -> iss_vld = 4'b0001 two cycles after disp_vld (accept in t, select in t+1, drive in t+2), iss_des = 1; iq_count returns to 0.
- Dependency: dispatch r4 <- r1 while r1 is busy -> no issue until wb_vld[2] = 1 with wb_des = 1; issue appears in the next cycle (bypass).
- Fill: dispatch 16 instructions that all depend on busy r5 -> iq_full = 1 and disp_rdy = 0. Then writeback r5 -> 4 issue per cycle, oldest first (entries 0-3, then 4-7...); disp_rdy reasserts in the cycle the first 4 are selected.
- WAW: lane0 des = r6 and lane1 des = r6 in the same cycle -> disp_rdy = 2'b01; lane1 is accepted only after r6 is written back.
- Flush: queue holds tags 0, 1, 2, 1; flush_en with mask = 8'b0000_0010 and flush_reg = r7 -> only the tag 0 and tag 2 entries remain; iq_count = 2; r7 not busy; simultaneous disp_vld is rejected.
- Async reset asserted mid-issue with the queue at 9 entries -> all outputs zero immediately; iq_empty = 1 after release.

Source files
------------

// File: rtl/iq_pkg.sv
// Shared types and constants for the issue queue scheduler.
// Provides the queue entry record, the default field widths used by that
// record, and a constant-evaluable ceil(log2) helper used to size counters.
package iq_pkg;

    localparam int unsigned ENT_REG_W = 4;
    localparam int unsigned ENT_OP_W  = 4;
    localparam int unsigned ENT_IMM_W = 5;
    localparam int unsigned ENT_BID_W = 3;

    typedef struct packed {
        logic                 vld;
        logic [ENT_REG_W-1:0] des;
        logic [ENT_REG_W-1:0] s1;
        logic [ENT_REG_W-1:0] s2;
        logic                 des_use;
        logic                 s1_use;
        logic                 s2_use;
        logic [ENT_OP_W-1:0]  op;
        logic [ENT_IMM_W-1:0] imm;
        logic [ENT_BID_W-1:0] bid;
    } iq_entry_t;

    // Smallest r with 2**r >= v (0 for v <= 1).
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((32'd1 << i) < v) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/iq_oldest_select.sv
// Oldest-first multi-grant selector.
// Ports:
//   req_i  - one bit per queue entry, set when the entry may issue.
//   gnt_o  - ISSUE_W one-hot (or zero) grant vectors; gnt_o[k] picks the
//            k-th lowest-index requester, so lower lanes get older entries.
module iq_oldest_select
    import iq_pkg::*;
#(
    parameter int unsigned DEPTH   = 16,
    parameter int unsigned ISSUE_W = 4
) (
    input  logic [DEPTH-1:0]              req_i,
    output logic [ISSUE_W-1:0][DEPTH-1:0] gnt_o
);

    logic [DEPTH-1:0] rem;

    always_comb begin
        rem   = req_i;
        gnt_o = '0;
        for (int k = 0; k < ISSUE_W; k++) begin
            // Isolate the lowest set bit, then retire it for the next lane.
            gnt_o[k] = rem & (~rem + DEPTH'(1));
            rem      = rem & ~gnt_o[k];
        end
    end

endmodule

// File: rtl/issue_queue_sched.sv
// Collapsing out-of-order issue queue with an integrated register scoreboard.
// Ports:
//   clk_i, rst_ni        - clock, asynchronous active-low reset.
//   disp_*_i / disp_rdy_o - DISP_W dispatch lanes; rdy is combinational and
//                           accepts lanes strictly in order.
//   wb_vld_i, wb_des_i   - writeback ports; clear busy bits and wake up
//                           dependent entries in the same cycle.
//   flush_en_i, flush_bid_mask_i, flush_reg_i - selective branch-tag flush
//                           and scoreboard clear.
//   iss_*_o              - ISSUE_W registered issue lanes, packed from lane 0.
//   iq_count_o, iq_full_o, iq_empty_o - occupancy status.
module issue_queue_sched
    import iq_pkg::*;
#(
    parameter int unsigned DEPTH   = 16,
    parameter int unsigned DISP_W  = 2,
    parameter int unsigned ISSUE_W = 4,
    parameter int unsigned WB_W    = 4,
    parameter int unsigned REG_NUM = 16,
    parameter int unsigned REG_W   = ENT_REG_W,
    parameter int unsigned OP_W    = ENT_OP_W,
    parameter int unsigned IMM_W   = ENT_IMM_W,
    parameter int unsigned BID_W   = ENT_BID_W
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic [DISP_W-1:0]              disp_vld_i,
    output logic [DISP_W-1:0]              disp_rdy_o,
    input  logic [DISP_W*REG_W-1:0]        disp_des_i,
    input  logic [DISP_W*REG_W-1:0]        disp_s1_i,
    input  logic [DISP_W*REG_W-1:0]        disp_s2_i,
    input  logic [DISP_W-1:0]              disp_s1_use_i,
    input  logic [DISP_W-1:0]              disp_s2_use_i,
    input  logic [DISP_W-1:0]              disp_des_use_i,
    input  logic [DISP_W*OP_W-1:0]         disp_op_i,
    input  logic [DISP_W*IMM_W-1:0]        disp_imm_i,
    input  logic [DISP_W*BID_W-1:0]        disp_bid_i,
    input  logic [WB_W-1:0]                wb_vld_i,
    input  logic [WB_W*REG_W-1:0]          wb_des_i,
    input  logic                           flush_en_i,
    input  logic [(1<<BID_W)-1:0]          flush_bid_mask_i,
    input  logic [REG_NUM-1:0]             flush_reg_i,
    output logic [ISSUE_W-1:0]             iss_vld_o,
    output logic [ISSUE_W*REG_W-1:0]       iss_des_o,
    output logic [ISSUE_W*REG_W-1:0]       iss_s1_o,
    output logic [ISSUE_W*REG_W-1:0]       iss_s2_o,
    output logic [ISSUE_W*OP_W-1:0]        iss_op_o,
    output logic [ISSUE_W*IMM_W-1:0]       iss_imm_o,
    output logic [ISSUE_W*BID_W-1:0]       iss_bid_o,
    output logic [clog2(DEPTH+1)-1:0]      iq_count_o,
    output logic                           iq_full_o,
    output logic                           iq_empty_o
);

    localparam int unsigned CNT_W = clog2(DEPTH + 1);

    iq_entry_t                ent_q [DEPTH];
    iq_entry_t                ent_d [DEPTH];
    logic [REG_NUM-1:0]       busy_q, busy_d;
    logic [CNT_W-1:0]         count_q, count_d;

    logic [ISSUE_W-1:0]       iss_vld_q, iss_vld_d;
    logic [ISSUE_W*REG_W-1:0] iss_des_q, iss_des_d;
    logic [ISSUE_W*REG_W-1:0] iss_s1_q, iss_s1_d;
    logic [ISSUE_W*REG_W-1:0] iss_s2_q, iss_s2_d;
    logic [ISSUE_W*OP_W-1:0]  iss_op_q, iss_op_d;
    logic [ISSUE_W*IMM_W-1:0] iss_imm_q, iss_imm_d;
    logic [ISSUE_W*BID_W-1:0] iss_bid_q, iss_bid_d;

    logic [REG_NUM-1:0]              wb_hit;
    logic [DEPTH-1:0]                kill;
    logic [DEPTH-1:0]                req;
    logic [DEPTH-1:0]                issued;
    logic [ISSUE_W-1:0][DEPTH-1:0]   gnt;
    logic [DISP_W-1:0]               acc;
    int unsigned                     n_issued;
    int unsigned                     free;
    logic                            prev_ok;
    logic                            waw;
    int unsigned                     pos;

    // Registers written back this cycle; used for both wakeup and busy clear.
    always_comb begin
        wb_hit = '0;
        for (int w = 0; w < WB_W; w++) begin
            if (wb_vld_i[w]) begin
                wb_hit[wb_des_i[w*REG_W +: REG_W]] = 1'b1;
            end
        end
    end

    always_comb begin
        kill = '0;
        req  = '0;
        for (int e = 0; e < DEPTH; e++) begin
            kill[e] = ent_q[e].vld && flush_en_i && flush_bid_mask_i[ent_q[e].bid];
            req[e]  = ent_q[e].vld && !kill[e]
                   && (!ent_q[e].s1_use || !busy_q[ent_q[e].s1] || wb_hit[ent_q[e].s1])
                   && (!ent_q[e].s2_use || !busy_q[ent_q[e].s2] || wb_hit[ent_q[e].s2]);
        end
    end

    iq_oldest_select #(
        .DEPTH   (DEPTH),
        .ISSUE_W (ISSUE_W)
    ) u_select (
        .req_i (req),
        .gnt_o (gnt)
    );

    // Issue mux: lane k takes the entry granted to it, otherwise all zeros.
    always_comb begin
        issued    = '0;
        iss_vld_d = '0;
        iss_des_d = '0;
        iss_s1_d  = '0;
        iss_s2_d  = '0;
        iss_op_d  = '0;
        iss_imm_d = '0;
        iss_bid_d = '0;
        for (int k = 0; k < ISSUE_W; k++) begin
            for (int e = 0; e < DEPTH; e++) begin
                if (gnt[k][e]) begin
                    issued[e]                    = 1'b1;
                    iss_vld_d[k]                 = 1'b1;
                    iss_des_d[k*REG_W +: REG_W]  = ent_q[e].des;
                    iss_s1_d[k*REG_W +: REG_W]   = ent_q[e].s1;
                    iss_s2_d[k*REG_W +: REG_W]   = ent_q[e].s2;
                    iss_op_d[k*OP_W +: OP_W]     = ent_q[e].op;
                    iss_imm_d[k*IMM_W +: IMM_W]  = ent_q[e].imm;
                    iss_bid_d[k*BID_W +: BID_W]  = ent_q[e].bid;
                end
            end
        end
    end

    // Dispatch acceptance: in order, bounded by slots freed this cycle,
    // blocked by WAW on busy or earlier-lane destinations and by flush.
    always_comb begin
        n_issued = 0;
        for (int e = 0; e < DEPTH; e++) begin
            n_issued = n_issued + 32'(issued[e]);
        end
        free    = DEPTH - 32'(count_q) + n_issued;
        acc     = '0;
        prev_ok = 1'b1;
        waw     = 1'b0;
        for (int unsigned i = 0; i < DISP_W; i++) begin
            waw = disp_des_use_i[i] && busy_q[disp_des_i[i*REG_W +: REG_W]];
            for (int unsigned j = 0; j < i; j++) begin
                if (disp_des_use_i[i] && disp_des_use_i[j] && acc[j]
                    && (disp_des_i[i*REG_W +: REG_W] == disp_des_i[j*REG_W +: REG_W])) begin
                    waw = 1'b1;
                end
            end
            acc[i]  = rst_ni && !flush_en_i && disp_vld_i[i] && prev_ok && (free > i) && !waw;
            prev_ok = acc[i];
        end
    end

    assign disp_rdy_o = acc;

    // Collapse survivors toward index 0, then append accepted lanes.
    always_comb begin
        for (int e = 0; e < DEPTH; e++) begin
            ent_d[e] = '0;
        end
        pos = 0;
        for (int e = 0; e < DEPTH; e++) begin
            if (ent_q[e].vld && !issued[e] && !kill[e]) begin
                ent_d[pos] = ent_q[e];
                pos        = pos + 1;
            end
        end
        for (int unsigned i = 0; i < DISP_W; i++) begin
            if (acc[i] && (pos < DEPTH)) begin
                ent_d[pos].vld     = 1'b1;
                ent_d[pos].des     = disp_des_i[i*REG_W +: REG_W];
                ent_d[pos].s1      = disp_s1_i[i*REG_W +: REG_W];
                ent_d[pos].s2      = disp_s2_i[i*REG_W +: REG_W];
                ent_d[pos].des_use = disp_des_use_i[i];
                ent_d[pos].s1_use  = disp_s1_use_i[i];
                ent_d[pos].s2_use  = disp_s2_use_i[i];
                ent_d[pos].op      = disp_op_i[i*OP_W +: OP_W];
                ent_d[pos].imm     = disp_imm_i[i*IMM_W +: IMM_W];
                ent_d[pos].bid     = disp_bid_i[i*BID_W +: BID_W];
                pos                = pos + 1;
            end
        end
        count_d = CNT_W'(pos);
    end

    // Scoreboard: clears first, dispatch sets last so set wins.
    always_comb begin
        busy_d = busy_q & ~wb_hit;
        if (flush_en_i) begin
            busy_d = busy_d & ~flush_reg_i;
        end
        for (int unsigned i = 0; i < DISP_W; i++) begin
            if (acc[i] && disp_des_use_i[i]) begin
                busy_d[disp_des_i[i*REG_W +: REG_W]] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int e = 0; e < DEPTH; e++) begin
                ent_q[e] <= '0;
            end
            busy_q    <= '0;
            count_q   <= '0;
            iss_vld_q <= '0;
            iss_des_q <= '0;
            iss_s1_q  <= '0;
            iss_s2_q  <= '0;
            iss_op_q  <= '0;
            iss_imm_q <= '0;
            iss_bid_q <= '0;
        end else begin
            for (int e = 0; e < DEPTH; e++) begin
                ent_q[e] <= ent_d[e];
            end
            busy_q    <= busy_d;
            count_q   <= count_d;
            iss_vld_q <= iss_vld_d;
            iss_des_q <= iss_des_d;
            iss_s1_q  <= iss_s1_d;
            iss_s2_q  <= iss_s2_d;
            iss_op_q  <= iss_op_d;
            iss_imm_q <= iss_imm_d;
            iss_bid_q <= iss_bid_d;
        end
    end

    assign iss_vld_o  = iss_vld_q;
    assign iss_des_o  = iss_des_q;
    assign iss_s1_o   = iss_s1_q;
    assign iss_s2_o   = iss_s2_q;
    assign iss_op_o   = iss_op_q;
    assign iss_imm_o  = iss_imm_q;
    assign iss_bid_o  = iss_bid_q;
    assign iq_count_o = count_q;
    assign iq_full_o  = (count_q == CNT_W'(DEPTH));
    assign iq_empty_o = (count_q == '0);

endmodule

// File: tb/tb_issue_queue_sched.sv
// Directed testbench for issue_queue_sched: reset, single issue, wakeup
// bypass, fill/drain ordering, WAW blocking, selective flush, async reset.
module tb_issue_queue_sched;

    logic        clk_i;
    logic        rst_ni;
    logic [1:0]  disp_vld_i;
    logic [1:0]  disp_rdy_o;
    logic [7:0]  disp_des_i;
    logic [7:0]  disp_s1_i;
    logic [7:0]  disp_s2_i;
    logic [1:0]  disp_s1_use_i;
    logic [1:0]  disp_s2_use_i;
    logic [1:0]  disp_des_use_i;
    logic [7:0]  disp_op_i;
    logic [9:0]  disp_imm_i;
    logic [5:0]  disp_bid_i;
    logic [3:0]  wb_vld_i;
    logic [15:0] wb_des_i;
    logic        flush_en_i;
    logic [7:0]  flush_bid_mask_i;
    logic [15:0] flush_reg_i;
    logic [3:0]  iss_vld_o;
    logic [15:0] iss_des_o;
    logic [15:0] iss_s1_o;
    logic [15:0] iss_s2_o;
    logic [15:0] iss_op_o;
    logic [19:0] iss_imm_o;
    logic [11:0] iss_bid_o;
    logic [4:0]  iq_count_o;
    logic        iq_full_o;
    logic        iq_empty_o;

    int n_assert;
    int n_fail;

    issue_queue_sched dut (
        .clk_i            (clk_i),
        .rst_ni           (rst_ni),
        .disp_vld_i       (disp_vld_i),
        .disp_rdy_o       (disp_rdy_o),
        .disp_des_i       (disp_des_i),
        .disp_s1_i        (disp_s1_i),
        .disp_s2_i        (disp_s2_i),
        .disp_s1_use_i    (disp_s1_use_i),
        .disp_s2_use_i    (disp_s2_use_i),
        .disp_des_use_i   (disp_des_use_i),
        .disp_op_i        (disp_op_i),
        .disp_imm_i       (disp_imm_i),
        .disp_bid_i       (disp_bid_i),
        .wb_vld_i         (wb_vld_i),
        .wb_des_i         (wb_des_i),
        .flush_en_i       (flush_en_i),
        .flush_bid_mask_i (flush_bid_mask_i),
        .flush_reg_i      (flush_reg_i),
        .iss_vld_o        (iss_vld_o),
        .iss_des_o        (iss_des_o),
        .iss_s1_o         (iss_s1_o),
        .iss_s2_o         (iss_s2_o),
        .iss_op_o         (iss_op_o),
        .iss_imm_o        (iss_imm_o),
        .iss_bid_o        (iss_bid_o),
        .iq_count_o       (iq_count_o),
        .iq_full_o        (iq_full_o),
        .iq_empty_o       (iq_empty_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic clr_disp();
        disp_vld_i     = '0;
        disp_des_i     = '0;
        disp_s1_i      = '0;
        disp_s2_i      = '0;
        disp_s1_use_i  = '0;
        disp_s2_use_i  = '0;
        disp_des_use_i = '0;
        disp_op_i      = '0;
        disp_imm_i     = '0;
        disp_bid_i     = '0;
    endtask

    task automatic set_lane(input int lane, input logic [3:0] des, input logic desu,
                            input logic [3:0] s1, input logic s1u,
                            input logic [3:0] s2, input logic s2u,
                            input logic [3:0] op, input logic [4:0] imm,
                            input logic [2:0] bid);
        disp_vld_i[lane]         = 1'b1;
        disp_des_i[lane*4 +: 4]  = des;
        disp_des_use_i[lane]     = desu;
        disp_s1_i[lane*4 +: 4]   = s1;
        disp_s1_use_i[lane]      = s1u;
        disp_s2_i[lane*4 +: 4]   = s2;
        disp_s2_use_i[lane]      = s2u;
        disp_op_i[lane*4 +: 4]   = op;
        disp_imm_i[lane*5 +: 5]  = imm;
        disp_bid_i[lane*3 +: 3]  = bid;
    endtask

    initial begin
        n_assert         = 0;
        n_fail           = 0;
        rst_ni           = 1'b0;
        wb_vld_i         = '0;
        wb_des_i         = '0;
        flush_en_i       = 1'b0;
        flush_bid_mask_i = '0;
        flush_reg_i      = '0;
        clr_disp();

        // Reset state
        #7;
        set_lane(0, 4'd1, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 5'd0, 3'd0);
        #1;
        chk("rst_rdy", disp_rdy_o, 2'b00);
        chk("rst_iss_vld", iss_vld_o, 4'h0);
        chk("rst_count", iq_count_o, 5'd0);
        chk("rst_empty", iq_empty_o, 1'b1);
        chk("rst_full", iq_full_o, 1'b0);
        clr_disp();
        #4 rst_ni = 1'b1;
        step();

        // Single independent instruction r1 <- r2, r3
        set_lane(0, 4'd1, 1'b1, 4'd2, 1'b1, 4'd3, 1'b1, 4'd1, 5'd3, 3'd0);
        #1 chk("t1_rdy", disp_rdy_o, 2'b01);
        step();
        clr_disp();
        chk("t1_count1", iq_count_o, 5'd1);
        chk("t1_no_iss_yet", iss_vld_o, 4'h0);
        step();
        chk("t1_iss_vld", iss_vld_o, 4'b0001);
        chk("t1_iss_des", iss_des_o, 16'h0001);
        chk("t1_iss_s1", iss_s1_o, 16'h0002);
        chk("t1_iss_s2", iss_s2_o, 16'h0003);
        chk("t1_iss_op", iss_op_o, 16'h0001);
        chk("t1_iss_imm", iss_imm_o, 20'h00003);
        chk("t1_count0", iq_count_o, 5'd0);
        chk("t1_empty", iq_empty_o, 1'b1);

        // Dependency on busy r1, woken by writeback port 2
        set_lane(0, 4'd4, 1'b1, 4'd1, 1'b1, 4'd0, 1'b0, 4'd2, 5'd0, 3'd0);
        #1 chk("t2_rdy", disp_rdy_o, 2'b01);
        step();
        clr_disp();
        step();
        chk("t2_blocked", iss_vld_o, 4'h0);
        chk("t2_count1", iq_count_o, 5'd1);
        wb_vld_i = 4'b0100;
        wb_des_i = 16'h0100;
        #1 step();
        wb_vld_i = '0;
        wb_des_i = '0;
        chk("t2_bypass_vld", iss_vld_o, 4'b0001);
        chk("t2_bypass_des", iss_des_o, 16'h0004);
        chk("t2_count0", iq_count_o, 5'd0);

        // Fill with 16 consumers of busy r5, then drain oldest first
        set_lane(0, 4'd5, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 5'd0, 3'd0);
        #1 step();
        clr_disp();
        step();
        for (int c = 0; c < 8; c++) begin
            set_lane(0, 4'd0, 1'b0, 4'd5, 1'b1, 4'd0, 1'b0, 4'(2*c), 5'(2*c), 3'd0);
            set_lane(1, 4'd0, 1'b0, 4'd5, 1'b1, 4'd0, 1'b0, 4'(2*c+1), 5'(2*c+1), 3'd0);
            #1 chk("t3_fill_rdy", disp_rdy_o, 2'b11);
            step();
        end
        clr_disp();
        chk("t3_count16", iq_count_o, 5'd16);
        chk("t3_full", iq_full_o, 1'b1);
        set_lane(0, 4'd0, 1'b0, 4'd5, 1'b1, 4'd0, 1'b0, 4'd0, 5'd0, 3'd0);
        #1 chk("t3_full_rdy", disp_rdy_o, 2'b00);
        wb_vld_i = 4'b0001;
        wb_des_i = 16'h0005;
        #1 chk("t3_reopen_rdy", disp_rdy_o, 2'b01);
        clr_disp();
        #1 step();
        wb_vld_i = '0;
        wb_des_i = '0;
        chk("t3_d0_vld", iss_vld_o, 4'hF);
        chk("t3_d0_op", iss_op_o, 16'h3210);
        chk("t3_d0_count", iq_count_o, 5'd12);
        chk("t3_d0_full", iq_full_o, 1'b0);
        step();
        chk("t3_d1_op", iss_op_o, 16'h7654);
        chk("t3_d1_count", iq_count_o, 5'd8);
        step();
        chk("t3_d2_op", iss_op_o, 16'hBA98);
        chk("t3_d2_count", iq_count_o, 5'd4);
        step();
        chk("t3_d3_op", iss_op_o, 16'hFEDC);
        chk("t3_d3_count", iq_count_o, 5'd0);
        step();
        chk("t3_idle_vld", iss_vld_o, 4'h0);
        chk("t3_empty", iq_empty_o, 1'b1);

        // WAW: both lanes write r6
        set_lane(0, 4'd6, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd1, 5'd0, 3'd0);
        set_lane(1, 4'd6, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd2, 5'd0, 3'd0);
        #1 chk("t4_rdy_pair", disp_rdy_o, 2'b01);
        step();
        clr_disp();
        set_lane(0, 4'd6, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd2, 5'd0, 3'd0);
        #1 chk("t4_rdy_busy", disp_rdy_o, 2'b00);
        wb_vld_i = 4'b0001;
        wb_des_i = 16'h0006;
        #1 chk("t4_rdy_wb_same", disp_rdy_o, 2'b00);
        step();
        wb_vld_i = '0;
        wb_des_i = '0;
        chk("t4_a_vld", iss_vld_o, 4'b0001);
        chk("t4_a_op", iss_op_o, 16'h0001);
        #1 chk("t4_rdy_free", disp_rdy_o, 2'b01);
        step();
        clr_disp();
        chk("t4_count1", iq_count_o, 5'd1);
        step();
        chk("t4_b_vld", iss_vld_o, 4'b0001);
        chk("t4_b_op", iss_op_o, 16'h0002);
        chk("t4_b_des", iss_des_o, 16'h0006);

        // Flush tag 1 from a queue holding tags 0,1,2,1
        set_lane(0, 4'd8, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 5'd0, 3'd0);
        #1 step();
        clr_disp();
        step();
        set_lane(0, 4'd7, 1'b1, 4'd8, 1'b1, 4'd0, 1'b0, 4'hA, 5'd0, 3'd0);
        set_lane(1, 4'd0, 1'b0, 4'd8, 1'b1, 4'd0, 1'b0, 4'hB, 5'd0, 3'd1);
        #1 step();
        set_lane(0, 4'd0, 1'b0, 4'd8, 1'b1, 4'd0, 1'b0, 4'hC, 5'd0, 3'd2);
        set_lane(1, 4'd0, 1'b0, 4'd8, 1'b1, 4'd0, 1'b0, 4'hD, 5'd0, 3'd1);
        #1 step();
        clr_disp();
        chk("t5_count4", iq_count_o, 5'd4);
        flush_en_i       = 1'b1;
        flush_bid_mask_i = 8'b0000_0010;
        flush_reg_i      = 16'h0080;
        set_lane(0, 4'd3, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 5'd0, 3'd0);
        #1 chk("t5_flush_rdy", disp_rdy_o, 2'b00);
        step();
        flush_en_i       = 1'b0;
        flush_bid_mask_i = '0;
        flush_reg_i      = '0;
        clr_disp();
        chk("t5_count2", iq_count_o, 5'd2);
        chk("t5_no_iss", iss_vld_o, 4'h0);
        set_lane(0, 4'd7, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 5'd0, 3'd0);
        #1 chk("t5_r7_free", disp_rdy_o, 2'b01);
        clr_disp();
        wb_vld_i = 4'b0010;
        wb_des_i = 16'h0080;
        #1 step();
        wb_vld_i = '0;
        wb_des_i = '0;
        chk("t5_surv_vld", iss_vld_o, 4'b0011);
        chk("t5_surv_op", iss_op_o, 16'h00CA);
        chk("t5_surv_bid", iss_bid_o, 12'h010);
        chk("t5_count0", iq_count_o, 5'd0);

        // Async reset while issuing with 9 entries left
        set_lane(0, 4'd9, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 5'd0, 3'd0);
        #1 step();
        clr_disp();
        step();
        for (int c = 0; c < 7; c++) begin
            clr_disp();
            set_lane(0, 4'd0, 1'b0, 4'd9, 1'b1, 4'd0, 1'b0, 4'(2*c), 5'd0, 3'd0);
            if (c < 6) begin
                set_lane(1, 4'd0, 1'b0, 4'd9, 1'b1, 4'd0, 1'b0, 4'(2*c+1), 5'd0, 3'd0);
            end
            #1 step();
        end
        clr_disp();
        chk("t6_count13", iq_count_o, 5'd13);
        wb_vld_i = 4'b1000;
        wb_des_i = 16'h9000;
        #1 step();
        wb_vld_i = '0;
        wb_des_i = '0;
        chk("t6_pre_vld", iss_vld_o, 4'hF);
        chk("t6_pre_op", iss_op_o, 16'h3210);
        chk("t6_pre_count", iq_count_o, 5'd9);
        #2 rst_ni = 1'b0;
        set_lane(0, 4'd10, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 5'd0, 3'd0);
        #1;
        chk("t6_rst_vld", iss_vld_o, 4'h0);
        chk("t6_rst_op", iss_op_o, 16'h0000);
        chk("t6_rst_count", iq_count_o, 5'd0);
        chk("t6_rst_empty", iq_empty_o, 1'b1);
        chk("t6_rst_rdy", disp_rdy_o, 2'b00);
        clr_disp();
        #1 rst_ni = 1'b1;
        step();
        chk("t6_post_empty", iq_empty_o, 1'b1);
        chk("t6_post_count", iq_count_o, 5'd0);
        chk("t6_post_vld", iss_vld_o, 4'h0);
        // r4 was left busy before reset; reset must have cleared it
        set_lane(0, 4'd4, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 5'd0, 3'd0);
        #1 chk("t6_sb_cleared", disp_rdy_o, 2'b01);
        clr_disp();
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
